// File: rtl/shift_add_datapath.sv
// Datapath half of a shift-add multiplier: executes sequencer commands on {C,A,Q} and M,
// captures the 2N-bit product on ready and flags mis-sequenced commands.
module shift_add_datapath #(
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           n_rst,
  input  logic           reset,
  input  logic           add,
  input  logic           shift,
  input  logic           ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           Q0,
  output logic [2*N-1:0] product,
  output logic           product_valid,
  output logic           seq_error
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * N;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_LOAD,
    CMD_CONFLICT,
    CMD_ADD,
    CMD_SHIFT,
    CMD_READY
  } cmd_t;

  logic [N-1:0]  m_reg, m_nxt;
  logic [N-1:0]  a_reg, a_nxt;
  logic          c_reg, c_nxt;
  logic [N-1:0]  q_reg, q_nxt;
  logic [CW-1:0] cnt_reg, cnt_nxt;
  logic [PW-1:0] product_reg, product_nxt;
  logic          valid_reg, valid_nxt;
  logic          err_reg, err_nxt;

  cmd_t          cmd;
  logic          cnt_full;
  logic [N:0]    sum;

  // Priority decode of the command strobes; illegal combinations collapse to CMD_CONFLICT.
  always_comb begin
    cmd = CMD_HOLD;
    if (reset) begin
      cmd = CMD_LOAD;
    end else if (add && shift) begin
      cmd = CMD_CONFLICT;
    end else if (ready && (add || shift)) begin
      cmd = CMD_CONFLICT;
    end else if (add) begin
      cmd = CMD_ADD;
    end else if (shift) begin
      cmd = CMD_SHIFT;
    end else if (ready) begin
      cmd = CMD_READY;
    end
  end

  assign cnt_full = (cnt_reg == CW'(N));
  assign sum      = {1'b0, a_reg} + {1'b0, m_reg};

  // Next-state for all datapath and status registers.
  always_comb begin
    m_nxt       = m_reg;
    a_nxt       = a_reg;
    c_nxt       = c_reg;
    q_nxt       = q_reg;
    cnt_nxt     = cnt_reg;
    product_nxt = product_reg;
    valid_nxt   = valid_reg;
    err_nxt     = err_reg;

    unique case (cmd)
      CMD_LOAD: begin
        m_nxt     = multiplicand;
        q_nxt     = multiplier;
        a_nxt     = '0;
        c_nxt     = 1'b0;
        cnt_nxt   = '0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
      end
      CMD_CONFLICT: begin
        err_nxt = 1'b1;
      end
      CMD_ADD: begin
        if (cnt_full) begin
          err_nxt = 1'b1;
        end else begin
          {c_nxt, a_nxt} = sum;
        end
      end
      CMD_SHIFT: begin
        if (cnt_full) begin
          err_nxt = 1'b1;
        end else begin
          a_nxt   = {c_reg, a_reg[N-1:1]};
          q_nxt   = {a_reg[0], q_reg[N-1:1]};
          c_nxt   = 1'b0;
          cnt_nxt = CW'(cnt_reg + CW'(1));
        end
      end
      CMD_READY: begin
        // A repeated ready after capture is harmless and leaves everything as is.
        if (!cnt_full) begin
          err_nxt = 1'b1;
        end else if (!valid_reg) begin
          product_nxt = {a_reg, q_reg};
          valid_nxt   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      m_reg       <= '0;
      a_reg       <= '0;
      c_reg       <= 1'b0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      m_reg       <= m_nxt;
      a_reg       <= a_nxt;
      c_reg       <= c_nxt;
      q_reg       <= q_nxt;
      cnt_reg     <= cnt_nxt;
      product_reg <= product_nxt;
      valid_reg   <= valid_nxt;
      err_reg     <= err_nxt;
    end
  end

  // Q0 is consumed by the sequencer in the same cycle, so it comes straight off the register.
  assign Q0            = q_reg[0];
  assign product       = product_reg;
  assign product_valid = valid_reg;
  assign seq_error     = err_reg;

endmodule

// File: tb/tb_shift_add_datapath.sv
// Bench for shift_add_datapath: table of operand/product vectors, protocol corner cases,
// and random operands checked against plain multiplication.
module tb_shift_add_datapath;

  localparam int unsigned N = 4;

  logic           clock;
  logic           n_rst;
  logic           reset;
  logic           add;
  logic           shift;
  logic           ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           Q0;
  logic [2*N-1:0] product;
  logic           product_valid;
  logic           seq_error;

  int checks = 0;
  int errors = 0;

  shift_add_datapath #(.N(N)) dut (
    .clock         (clock),
    .n_rst         (n_rst),
    .reset         (reset),
    .add           (add),
    .shift         (shift),
    .ready         (ready),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .Q0            (Q0),
    .product       (product),
    .product_valid (product_valid),
    .seq_error     (seq_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [N-1:0]   mc;
    logic [N-1:0]   mp;
    logic [2*N-1:0] exp_product;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One command cycle: strobes driven at negedge, sampled at posedge, cleared 1 time unit later.
  task automatic step(input logic r, input logic ad, input logic sh, input logic rd);
    @(negedge clock);
    reset = r; add = ad; shift = sh; ready = rd;
    @(posedge clock);
    #1;
    reset = 1'b0; add = 1'b0; shift = 1'b0; ready = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] mc, input logic [N-1:0] mp);
    multiplicand = mc;
    multiplier   = mp;
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Correct add/shift sequence for multiplier bits [from, to); Q0 must show multiplier bit i.
  task automatic run_steps(input logic [N-1:0] mp, input int from, input int to, input bit idles);
    logic [N-1:0] bits;
    bits = mp;
    for (int i = from; i < to; i++) begin
      chk("q0_before_shift", 16'(Q0), 16'(bits[i]));
      if (bits[i]) step(1'b0, 1'b1, 1'b0, 1'b0);
      if (idles && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic run_mult(input logic [N-1:0] mc, input logic [N-1:0] mp, input bit idles);
    int exp;
    exp = int'(mc) * int'(mp);
    load(mc, mp);
    chk("valid_after_load", 16'(product_valid), 16'd0);
    chk("err_after_load", 16'(seq_error), 16'd0);
    run_steps(mp, 0, N, idles);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("product", 16'(product), 16'(exp));
    chk("valid", 16'(product_valid), 16'd1);
    chk("err", 16'(seq_error), 16'd0);
  endtask

  initial begin
    logic [N-1:0] rmc, rmp;
    vecs[0] = '{4'hD, 4'hB, 8'h8F};
    vecs[1] = '{4'hF, 4'hF, 8'hE1};
    vecs[2] = '{4'h0, 4'h9, 8'h00};
    vecs[3] = '{4'h7, 4'h0, 8'h00};
    vecs[4] = '{4'h3, 4'h5, 8'h0F};
    vecs[5] = '{4'h1, 4'hF, 8'h0F};
    vecs[6] = '{4'h8, 4'h8, 8'h40};
    vecs[7] = '{4'hF, 4'h1, 8'h0F};

    reset = 1'b0; add = 1'b0; shift = 1'b0; ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    n_rst = 1'b0;
    #12;
    chk("rst_product", 16'(product), 16'd0);
    chk("rst_valid", 16'(product_valid), 16'd0);
    chk("rst_err", 16'(seq_error), 16'd0);
    chk("rst_q0", 16'(Q0), 16'd0);
    @(negedge clock);
    n_rst = 1'b1;

    // Table vectors; product also checked against the table's own expected value.
    foreach (vecs[k]) begin
      run_mult(vecs[k].mc, vecs[k].mp, 1'b0);
      chk("table_product", 16'(product), 16'(vecs[k].exp_product));
    end

    // Repeat ready is harmless; reset keeps the old product but clears valid.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("repeat_ready_product", 16'(product), 16'h0F);
    chk("repeat_ready_valid", 16'(product_valid), 16'd1);
    chk("repeat_ready_err", 16'(seq_error), 16'd0);
    load(4'h2, 4'h3);
    chk("load_keeps_product", 16'(product), 16'h0F);
    chk("load_clears_valid", 16'(product_valid), 16'd0);

    // add and shift together: flagged, no register change, sequence still completes.
    load(4'hD, 4'hB);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("conflict_err", 16'(seq_error), 16'd1);
    chk("conflict_q0", 16'(Q0), 16'd1);
    run_steps(4'hB, 0, N, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("conflict_product", 16'(product), 16'h8F);
    chk("conflict_valid", 16'(product_valid), 16'd1);
    chk("conflict_err_sticky", 16'(seq_error), 16'd1);
    load(4'hD, 4'hB);
    chk("err_cleared_by_load", 16'(seq_error), 16'd0);

    // ready together with shift is also a conflict.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ready_shift_err", 16'(seq_error), 16'd1);
    chk("ready_shift_q0", 16'(Q0), 16'd1);

    // Early ready after 3 shifts, then completion still captures the right product.
    load(4'hD, 4'hB);
    run_steps(4'hB, 0, 3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("early_ready_valid", 16'(product_valid), 16'd0);
    chk("early_ready_err", 16'(seq_error), 16'd1);
    run_steps(4'hB, 3, 4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("late_capture_product", 16'(product), 16'h8F);
    chk("late_capture_valid", 16'(product_valid), 16'd1);

    // Fifth shift and an add after saturation are rejected and leave {A,Q} intact.
    load(4'h6, 4'h7);
    run_steps(4'h7, 0, N, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fifth_shift_err", 16'(seq_error), 16'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_overrun_product", 16'(product), 16'd42);
    chk("after_overrun_valid", 16'(product_valid), 16'd1);

    // Asynchronous n_rst mid-operation clears all outputs immediately.
    load(4'hD, 4'hB);
    run_steps(4'hB, 0, 2, 1'b0);
    #1 n_rst = 1'b0;
    #1;
    chk("async_product", 16'(product), 16'd0);
    chk("async_valid", 16'(product_valid), 16'd0);
    chk("async_err", 16'(seq_error), 16'd0);
    chk("async_q0", 16'(Q0), 16'd0);
    @(negedge clock);
    n_rst = 1'b1;
    run_mult(4'h3, 4'h5, 1'b0);
    chk("after_async_product", 16'(product), 16'h0F);

    // Random operands with random idle cycles, against plain multiplication.
    for (int r = 0; r < 40; r++) begin
      rmc = N'($urandom_range(0, 15));
      rmp = N'($urandom_range(0, 15));
      run_mult(rmc, rmp, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
